// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and redirect controller for the 5-stage RV32I pipeline.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [XLEN-1:0]   id_rs1_value,
  input  logic [XLEN-1:0]   id_rs2_value,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_mem_ren,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic              ex_fence_i,
  input  logic              ex_ecall,
  input  logic              ex_mret,
  input  logic [XLEN-1:0]   ex_branch_pc,
  input  logic [XLEN-1:0]   ex_next_pc,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  input  logic              mem_mem_ren,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rdata_valid,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wen,
  input  logic [XLEN-1:0]   wb_value,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  input  logic              icache_clr_done,
  output logic [XLEN-1:0]   ex_rs1_in,
  output logic [XLEN-1:0]   ex_rs2_in,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_bubble,
  output logic              mem_stall,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              icache_clr,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              load_fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   fence_pc_q, fence_pc_d;

  // ---------------- operand forwarding ----------------
  logic            ex_fwd_en, mem_fwd_en, wb_fwd_en;
  logic [XLEN-1:0] mem_fwd_val;

  // A load in EX has no data yet; it falls through and is covered by the load-use stall.
  assign ex_fwd_en   = ex_valid & ex_wen & ~ex_mem_ren & (ex_rd != '0);
  assign mem_fwd_en  = mem_valid & mem_wen & (mem_rd != '0);
  assign wb_fwd_en   = wb_valid & wb_wen & (wb_rd != '0);
  assign mem_fwd_val = mem_mem_ren ? mem_rdata : mem_result;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ex_rs1_in = id_rs1_value;
    ex_rs2_in = id_rs2_value;
    if (rst_n) begin
      if (ex_fwd_en && (ex_rd == id_rs1))        ex_rs1_in = ex_result;
      else if (mem_fwd_en && (mem_rd == id_rs1)) ex_rs1_in = mem_fwd_val;
      else if (wb_fwd_en && (wb_rd == id_rs1))   ex_rs1_in = wb_value;

      if (ex_fwd_en && (ex_rd == id_rs2))        ex_rs2_in = ex_result;
      else if (mem_fwd_en && (mem_rd == id_rs2)) ex_rs2_in = mem_fwd_val;
      else if (wb_fwd_en && (wb_rd == id_rs2))   ex_rs2_in = wb_value;
    end
  end

  // ---------------- EX-stage decisions ----------------
  logic            mem_wait_req, load_use, ex_redirect, ex_fence;
  logic [XLEN-1:0] ex_target;

  assign mem_wait_req = mem_valid & mem_mem_ren & ~mem_rdata_valid;
  assign load_use     = id_valid & ex_valid & ex_mem_ren & (ex_rd != '0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign ex_redirect  = ex_valid & (ex_ecall | ex_mret | ex_jump | (ex_branch & ex_result[0]));
  assign ex_fence     = ex_valid & ex_fence_i;

  always_comb begin
    ex_target = ex_branch_pc;
    if (ex_ecall)     ex_target = mtvec;
    else if (ex_mret) ex_target = mepc;
    else if (ex_jump) ex_target = ex_result;
  end

  // ---------------- control FSM ----------------
  logic run_eval;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fence_pc_d     = fence_pc_q;
    run_eval       = 1'b0;
    if_stall       = 1'b0;
    id_stall       = 1'b0;
    ex_bubble      = 1'b0;
    mem_stall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    icache_clr     = 1'b0;
    load_fault     = 1'b0;

    case (state_q)
      ST_RUN: run_eval = 1'b1;
      ST_MEM_WAIT: begin
        // The cycle the data arrives behaves as RUN so the held EX instruction resolves now.
        if (mem_rdata_valid) begin
          run_eval = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          load_fault     = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = mtvec;
          ex_bubble      = 1'b1;
          state_d        = ST_RUN;
        end else begin
          mem_stall = 1'b1;
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        icache_clr = 1'b1;
        if_stall   = 1'b1;
        id_stall   = 1'b1;
        ex_bubble  = 1'b1;
        if (icache_clr_done) begin
          redirect_valid = 1'b1;
          redirect_pc    = fence_pc_q;
          state_d        = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (run_eval) begin
      state_d = ST_RUN;
      if (mem_wait_req) begin
        state_d   = ST_MEM_WAIT;
        cnt_d     = '0;
        mem_stall = 1'b1;
        if_stall  = 1'b1;
        id_stall  = 1'b1;
      end else if (ex_redirect) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_target;
        ex_bubble      = 1'b1;
      end else if (ex_fence) begin
        state_d    = ST_FLUSH;
        fence_pc_d = ex_next_pc;
        ex_bubble  = 1'b1;
      end else if (load_use) begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_bubble = 1'b1;
      end
    end

    // Outputs are quiet for the whole reset assertion, not just after the first edge.
    if (!rst_n) begin
      if_stall       = 1'b0;
      id_stall       = 1'b0;
      ex_bubble      = 1'b0;
      mem_stall      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      icache_clr     = 1'b0;
      load_fault     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      fence_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fence_pc_q <= fence_pc_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, if_stall};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, redirect_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle
// sequences and randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int T = 8;

  typedef struct {
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rs1_value, id_rs2_value;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_wen, ex_mem_ren;
    logic [31:0] ex_result;
    logic        ex_branch, ex_jump, ex_fence_i, ex_ecall, ex_mret;
    logic [31:0] ex_branch_pc, ex_next_pc;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_wen, mem_mem_ren;
    logic [31:0] mem_result, mem_rdata;
    logic        mem_rdata_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_value;
    logic [31:0] mtvec, mepc;
    logic        icache_clr_done;
  } in_t;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        if_stall, id_stall, ex_bubble, mem_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_clr, load_fault;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic [31:0] id_rs1_value, id_rs2_value;
  logic ex_valid;
  logic [4:0] ex_rd;
  logic ex_wen, ex_mem_ren;
  logic [31:0] ex_result;
  logic ex_branch, ex_jump, ex_fence_i, ex_ecall, ex_mret;
  logic [31:0] ex_branch_pc, ex_next_pc;
  logic mem_valid;
  logic [4:0] mem_rd;
  logic mem_wen, mem_mem_ren;
  logic [31:0] mem_result, mem_rdata;
  logic mem_rdata_valid;
  logic wb_valid;
  logic [4:0] wb_rd;
  logic wb_wen;
  logic [31:0] wb_value;
  logic [31:0] mtvec, mepc;
  logic icache_clr_done;
  logic [31:0] ex_rs1_in, ex_rs2_in;
  logic if_stall, id_stall, ex_bubble, mem_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic icache_clr, load_fault;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_value(id_rs1_value), .id_rs2_value(id_rs2_value),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_mem_ren(ex_mem_ren),
    .ex_result(ex_result), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_fence_i(ex_fence_i), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .ex_branch_pc(ex_branch_pc), .ex_next_pc(ex_next_pc),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_mem_ren(mem_mem_ren),
    .mem_result(mem_result), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_value(wb_value),
    .mtvec(mtvec), .mepc(mepc), .icache_clr_done(icache_clr_done),
    .ex_rs1_in(ex_rs1_in), .ex_rs2_in(ex_rs2_in),
    .if_stall(if_stall), .id_stall(id_stall), .ex_bubble(ex_bubble), .mem_stall(mem_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .icache_clr(icache_clr),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .load_fault(load_fault)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input out_t act, input out_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          m_wait = 0;      // cycles the MEM load has already been stalled; 0 = none
  bit          m_flush = 1'b0;
  logic [31:0] m_fence_pc = '0;

  function automatic logic [31:0] exp_operand(input in_t i, input logic [4:0] rs,
                                              input logic [31:0] rf);
    logic        live [3];
    logic [4:0]  dst  [3];
    logic [31:0] val  [3];
    live[0] = i.ex_valid & i.ex_wen & ~i.ex_mem_ren; dst[0] = i.ex_rd;  val[0] = i.ex_result;
    live[1] = i.mem_valid & i.mem_wen;               dst[1] = i.mem_rd; val[1] = i.mem_mem_ren ? i.mem_rdata : i.mem_result;
    live[2] = i.wb_valid & i.wb_wen;                 dst[2] = i.wb_rd;  val[2] = i.wb_value;
    for (int k = 0; k < 3; k++)
      if (live[k] && dst[k] == rs && rs != 5'd0) return val[k];
    return rf;
  endfunction

  task automatic model_eval(input in_t i, output out_t o, output int nw, output bit nf,
                            output logic [31:0] nfpc);
    logic        cond [4];
    logic [31:0] tgt  [4];
    o = '0;
    o.rs1 = i.id_rs1_value;
    o.rs2 = i.id_rs2_value;
    nw = m_wait; nf = m_flush; nfpc = m_fence_pc;
    if (!i.rst_n) begin
      nw = 0; nf = 1'b0; nfpc = '0;
      return;
    end
    o.rs1 = exp_operand(i, i.id_rs1, i.id_rs1_value);
    o.rs2 = exp_operand(i, i.id_rs2, i.id_rs2_value);
    if (m_flush) begin
      o.icache_clr = 1; o.if_stall = 1; o.id_stall = 1; o.ex_bubble = 1;
      if (i.icache_clr_done) begin
        o.redirect_valid = 1; o.redirect_pc = m_fence_pc; nf = 1'b0;
      end
      return;
    end
    if (m_wait > 0 && !i.mem_rdata_valid) begin
      if (m_wait == T) begin
        o.load_fault = 1; o.redirect_valid = 1; o.redirect_pc = i.mtvec; o.ex_bubble = 1;
        nw = 0;
      end else begin
        o.mem_stall = 1; o.if_stall = 1; o.id_stall = 1;
        nw = m_wait + 1;
      end
      return;
    end
    nw = 0;
    if (i.mem_valid && i.mem_mem_ren && !i.mem_rdata_valid) begin
      o.mem_stall = 1; o.if_stall = 1; o.id_stall = 1;
      nw = 1;
      return;
    end
    if (!i.ex_valid) return;
    cond[0] = i.ex_ecall;                   tgt[0] = i.mtvec;
    cond[1] = i.ex_mret;                    tgt[1] = i.mepc;
    cond[2] = i.ex_jump;                    tgt[2] = i.ex_result;
    cond[3] = i.ex_branch & i.ex_result[0]; tgt[3] = i.ex_branch_pc;
    for (int k = 0; k < 4; k++) begin
      if (cond[k]) begin
        o.redirect_valid = 1; o.redirect_pc = tgt[k]; o.ex_bubble = 1;
        return;
      end
    end
    if (i.ex_fence_i) begin
      o.ex_bubble = 1; nf = 1'b1; nfpc = i.ex_next_pc;
      return;
    end
    if (i.id_valid && i.ex_mem_ren && i.ex_rd != 5'd0 &&
        (i.ex_rd == i.id_rs1 || i.ex_rd == i.id_rs2)) begin
      o.if_stall = 1; o.id_stall = 1; o.ex_bubble = 1;
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic drive(input in_t i);
    rst_n = i.rst_n; id_valid = i.id_valid; id_rs1 = i.id_rs1; id_rs2 = i.id_rs2;
    id_rs1_value = i.id_rs1_value; id_rs2_value = i.id_rs2_value;
    ex_valid = i.ex_valid; ex_rd = i.ex_rd; ex_wen = i.ex_wen; ex_mem_ren = i.ex_mem_ren;
    ex_result = i.ex_result; ex_branch = i.ex_branch; ex_jump = i.ex_jump;
    ex_fence_i = i.ex_fence_i; ex_ecall = i.ex_ecall; ex_mret = i.ex_mret;
    ex_branch_pc = i.ex_branch_pc; ex_next_pc = i.ex_next_pc;
    mem_valid = i.mem_valid; mem_rd = i.mem_rd; mem_wen = i.mem_wen; mem_mem_ren = i.mem_mem_ren;
    mem_result = i.mem_result; mem_rdata = i.mem_rdata; mem_rdata_valid = i.mem_rdata_valid;
    wb_valid = i.wb_valid; wb_rd = i.wb_rd; wb_wen = i.wb_wen; wb_value = i.wb_value;
    mtvec = i.mtvec; mepc = i.mepc; icache_clr_done = i.icache_clr_done;
  endtask

  function automatic out_t sample();
    out_t o;
    o.rs1 = ex_rs1_in; o.rs2 = ex_rs2_in;
    o.if_stall = if_stall; o.id_stall = id_stall; o.ex_bubble = ex_bubble;
    o.mem_stall = mem_stall; o.redirect_valid = redirect_valid; o.redirect_pc = redirect_pc;
    o.icache_clr = icache_clr; o.load_fault = load_fault;
    return o;
  endfunction

  // Called just after a rising edge; returns DUT outputs and model prediction for this cycle.
  task automatic step(input in_t i, output out_t act, output out_t mexp);
    int nw; bit nf; logic [31:0] nfpc;
    drive(i);
    model_eval(i, mexp, nw, nf, nfpc);
    @(negedge clk);
    act = sample();
    @(posedge clk);
    m_wait = nw; m_flush = nf; m_fence_pc = nfpc;
    #1;
  endtask

  function automatic in_t base_in();
    in_t i;
    i = '{default: '0};
    i.rst_n = 1; i.id_valid = 1; i.id_rs1 = 5'd1; i.id_rs2 = 5'd2;
    i.id_rs1_value = 32'h1111_1111; i.id_rs2_value = 32'h2222_2222;
    i.mem_result = 32'hAAAA_0000; i.mem_rdata = 32'hBBBB_0000; i.mem_rdata_valid = 1;
    i.wb_value = 32'hCCCC_0000; i.mtvec = 32'h0000_0100; i.mepc = 32'h0000_0200;
    i.ex_branch_pc = 32'h0000_0300; i.ex_next_pc = 32'h0000_0404;
    return i;
  endfunction

  function automatic out_t idle_out();
    out_t o;
    o = '0; o.rs1 = 32'h1111_1111; o.rs2 = 32'h2222_2222;
    return o;
  endfunction

  function automatic in_t rand_in(input int low_data);
    in_t i;
    i.rst_n = ($urandom_range(0, 99) != 0);
    i.id_valid = ($urandom_range(0, 3) != 0);
    i.id_rs1 = 5'($urandom_range(0, 3)); i.id_rs2 = 5'($urandom_range(0, 3));
    i.id_rs1_value = $urandom; i.id_rs2_value = $urandom;
    i.ex_valid = ($urandom_range(0, 3) != 0);
    i.ex_rd = 5'($urandom_range(0, 3)); i.ex_wen = $urandom_range(0, 1) == 1;
    i.ex_mem_ren = ($urandom_range(0, 3) == 0); i.ex_result = $urandom;
    i.ex_branch = ($urandom_range(0, 3) == 0); i.ex_jump = ($urandom_range(0, 7) == 0);
    i.ex_fence_i = ($urandom_range(0, 15) == 0); i.ex_ecall = ($urandom_range(0, 15) == 0);
    i.ex_mret = ($urandom_range(0, 15) == 0);
    i.ex_branch_pc = $urandom; i.ex_next_pc = $urandom;
    i.mem_valid = $urandom_range(0, 1) == 1; i.mem_rd = 5'($urandom_range(0, 3));
    i.mem_wen = $urandom_range(0, 1) == 1; i.mem_mem_ren = $urandom_range(0, 1) == 1;
    i.mem_result = $urandom; i.mem_rdata = $urandom;
    i.mem_rdata_valid = low_data != 0 ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 70);
    i.wb_valid = $urandom_range(0, 1) == 1; i.wb_rd = 5'($urandom_range(0, 3));
    i.wb_wen = $urandom_range(0, 1) == 1; i.wb_value = $urandom;
    i.mtvec = $urandom; i.mepc = $urandom;
    i.icache_clr_done = ($urandom_range(0, 3) == 0);
    return i;
  endfunction

  vec_t vecs[$];

  task automatic add_vec(input string name, input in_t i, input out_t e);
    vec_t r;
    r.name = name; r.i = i; r.e = e;
    vecs.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    in_t  v;
    out_t e, act, mexp;
    int   cnt_a, cnt_b, first, pcv;

    v = base_in(); v.rst_n = 0;
    drive(v);
    @(posedge clk); #1;

    // Reset: busy inputs, all controls quiet, operands pass the register file.
    v = base_in(); v.rst_n = 0;
    v.ex_valid = 1; v.ex_wen = 1; v.ex_rd = 5'd1; v.ex_result = 32'h55;
    v.ex_jump = 1; v.mem_valid = 1; v.mem_mem_ren = 1; v.mem_rdata_valid = 0;
    v.icache_clr_done = 1;
    step(v, act, mexp);
    check("reset_outputs", act, idle_out());

    // ---------------- directed table (state stays RUN) ----------------
    v = base_in(); add_vec("idle", v, idle_out());
    v = base_in(); v.ex_valid = 1; v.ex_wen = 1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.ex_result = 32'h1234;
    e = idle_out(); e.rs1 = 32'h1234; add_vec("fwd_ex", v, e);
    v.mem_valid = 1; v.mem_wen = 1; v.mem_rd = 5'd5; v.wb_valid = 1; v.wb_wen = 1; v.wb_rd = 5'd5;
    add_vec("fwd_ex_beats_mem_wb", v, e);
    v.ex_valid = 0;
    e = idle_out(); e.rs1 = 32'hAAAA_0000; add_vec("fwd_mem_beats_wb", v, e);
    v = base_in(); v.mem_valid = 1; v.mem_wen = 1; v.mem_mem_ren = 1; v.mem_rd = 5'd2;
    e = idle_out(); e.rs2 = 32'hBBBB_0000; add_vec("fwd_mem_load", v, e);
    v = base_in(); v.wb_valid = 1; v.wb_wen = 1; v.wb_rd = 5'd2;
    e = idle_out(); e.rs2 = 32'hCCCC_0000; add_vec("fwd_wb", v, e);
    v = base_in(); v.id_rs1 = 5'd0; v.ex_valid = 1; v.ex_wen = 1; v.ex_rd = 5'd0; v.ex_result = 32'h77;
    add_vec("no_fwd_x0", v, idle_out());
    v = base_in(); v.ex_valid = 1; v.ex_wen = 0; v.ex_rd = 5'd1; v.ex_result = 32'h78;
    add_vec("no_fwd_wen0", v, idle_out());
    v = base_in(); v.ex_valid = 1; v.ex_wen = 1; v.ex_mem_ren = 1; v.ex_rd = 5'd7; v.id_rs1 = 5'd7;
    e = idle_out(); e.if_stall = 1; e.id_stall = 1; e.ex_bubble = 1; add_vec("load_use_rs1", v, e);
    v.id_rs1 = 5'd1; v.id_rs2 = 5'd7; add_vec("load_use_rs2", v, e);
    v = base_in(); v.ex_valid = 1; v.ex_branch = 1; v.ex_result = 32'h1;
    e = idle_out(); e.redirect_valid = 1; e.redirect_pc = 32'h300; e.ex_bubble = 1;
    add_vec("branch_taken", v, e);
    v.ex_result = 32'h0; add_vec("branch_not_taken", v, idle_out());
    v = base_in(); v.ex_valid = 1; v.ex_ecall = 1; v.ex_jump = 1; v.ex_result = 32'h500;
    e = idle_out(); e.redirect_valid = 1; e.redirect_pc = 32'h100; e.ex_bubble = 1;
    add_vec("ecall_beats_jump", v, e);
    v = base_in(); v.ex_valid = 1; v.ex_mret = 1; v.ex_jump = 1; v.ex_result = 32'h504;
    e.redirect_pc = 32'h200; add_vec("mret_beats_jump", v, e);
    v.ex_mret = 0; e.redirect_pc = 32'h504; add_vec("jump", v, e);
    v.ex_valid = 0; add_vec("jump_invalid", v, idle_out());
    v = base_in(); v.icache_clr_done = 1; add_vec("clr_done_ignored", v, idle_out());

    foreach (vecs[k]) begin
      step(vecs[k].i, act, mexp);
      check(vecs[k].name, act, vecs[k].e);
    end

    // ---------------- LW x7 then dependent use ----------------
    v = base_in(); v.ex_valid = 1; v.ex_wen = 1; v.ex_mem_ren = 1; v.ex_rd = 5'd7; v.id_rs1 = 5'd7;
    step(v, act, mexp);
    e = idle_out(); e.if_stall = 1; e.id_stall = 1; e.ex_bubble = 1;
    check("lw_use_stall", act, e);
    v = base_in(); v.id_rs1 = 5'd7; v.mem_valid = 1; v.mem_wen = 1; v.mem_mem_ren = 1;
    v.mem_rd = 5'd7; v.mem_rdata = 32'hDEAD_BEEF;
    step(v, act, mexp);
    e = idle_out(); e.rs1 = 32'hDEAD_BEEF;
    check("lw_use_forward", act, e);

    // ---------------- 3-cycle memory wait with a held jump ----------------
    cnt_a = 0; first = -1;
    for (int c = 0; c < 6; c++) begin
      v = base_in(); v.ex_valid = 1; v.ex_jump = 1; v.ex_result = 32'h600;
      v.mem_valid = (c <= 3); v.mem_wen = 1; v.mem_mem_ren = 1; v.mem_rd = 5'd3;
      v.mem_rdata_valid = (c >= 3);
      step(v, act, mexp);
      check($sformatf("memwait_model[%0d]", c), act, mexp);
      if (act.mem_stall) cnt_a++;
      if (act.redirect_valid && first < 0) first = c;
    end
    check_int("memwait_stall_cycles", cnt_a, 3);
    check_int("memwait_redirect_cycle", first, 3);

    // ---------------- memory timeout ----------------
    cnt_a = 0; cnt_b = 0; first = -1; pcv = 0;
    for (int c = 0; c < T + 4; c++) begin
      v = base_in(); v.mem_valid = (c <= T); v.mem_wen = 1; v.mem_mem_ren = 1; v.mem_rd = 5'd3;
      v.mem_rdata_valid = 0;
      step(v, act, mexp);
      if (act.mem_stall) cnt_a++;
      if (act.load_fault) begin
        cnt_b++;
        if (first < 0) begin first = c; pcv = int'(act.redirect_pc); end
      end
    end
    check_int("timeout_stall_cycles", cnt_a, T);
    check_int("timeout_fault_pulses", cnt_b, 1);
    check_int("timeout_fault_cycle", first, T);
    check_int("timeout_redirect_pc", pcv, 32'h100);

    // ---------------- fence.i flush ----------------
    cnt_a = 0; first = -1; pcv = 0;
    for (int c = 0; c < 8; c++) begin
      v = base_in(); v.ex_valid = (c == 0); v.ex_fence_i = (c == 0); v.ex_next_pc = 32'h8000_0104;
      v.icache_clr_done = (c == 5);
      step(v, act, mexp);
      if (c == 0) begin
        e = idle_out(); e.ex_bubble = 1;
        check("fence_entry", act, e);
      end
      if (act.icache_clr) cnt_a++;
      if (act.redirect_valid && first < 0) begin first = c; pcv = int'(act.redirect_pc); end
    end
    check_int("fence_clr_cycles", cnt_a, 5);
    check_int("fence_redirect_cycle", first, 5);
    check_int("fence_redirect_pc", pcv, 32'h8000_0104);

    // ---------------- reset in the middle of FLUSH ----------------
    v = base_in(); v.ex_valid = 1; v.ex_fence_i = 1; v.ex_next_pc = 32'h8000_0200;
    step(v, act, mexp);
    v = base_in();
    step(v, act, mexp);
    check_int("flush_before_reset_clr", int'(act.icache_clr), 1);
    v = base_in(); v.rst_n = 0; v.icache_clr_done = 1;
    step(v, act, mexp);
    check("flush_reset_quiet", act, idle_out());
    cnt_a = 0;
    for (int c = 0; c < 3; c++) begin
      v = base_in(); v.icache_clr_done = 1;
      step(v, act, mexp);
      if (act.redirect_valid || act.icache_clr) cnt_a++;
    end
    check_int("flush_reset_no_redirect", cnt_a, 0);

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 3000; n++) begin
      v = rand_in((n / 250) % 2);
      step(v, act, mexp);
      check($sformatf("rand[%0d]", n), act, mexp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
